decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle decode stage.
- Decodes a 16-bit instruction: opcode [15:13], rs [12:10], rt [9:7], rd [6:4], imm [6:0].
- Reads an internal write-back-capable register file, sign-extends the immediate and registers all results into an ID/EX pipeline register with valid/ready handshake.
- Adds write-back bypass, load-use hazard stall and flush; sits between fetch and execute.

Parameters:
- DATA_W, 16, register/data width (>= IMM_W).
- IMM_W, 7, immediate field width taken from instruction[IMM_W-1:0].
- LOAD_OP, 3'b100, opcode that triggers load-use hazard detection.
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- instruction  in  16  instruction word.
- in_ready  out  1  stage accepts instruction this cycle (combinational).
- flush  in  1  kill current decode and pipeline register contents.
- wb_en  in  1  register-file write enable from write-back.
- wb_addr  in  3  write-back register index.
- wb_data  in  DATA_W  write-back data.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute accepts ID/EX contents.
- out_opcode  out  3  registered opcode.
- out_rs_data  out  DATA_W  registered rs read data.
- out_rt_data  out  DATA_W  registered rt read data.
- out_imm  out  DATA_W  registered sign-extended immediate.
- out_rt  out  3  registered rt index.
- out_rd  out  3  registered rd index.

Behaviour:
- Reset: on rising clk with rst=1, all 8 registers are 0, out_valid=0 and all out_* data/index fields are 0. rst overrides flush, wb_en and handshake in the same cycle.
- Register file: 8 x DATA_W, two combinational read ports (rs, rt) and one synchronous write port.
  - Write occurs on clk when wb_en=1.
  - With ZERO_REG=1, writes to addr 0 are dropped and reads of addr 0 return 0.
- Bypass: if wb_en=1 and wb_addr equals a read index (and is not reg 0 when ZERO_REG=1), that read returns wb_data in the same cycle.
- Sign extension: out_imm = {(DATA_W-IMM_W){instruction[IMM_W-1]}, instruction[IMM_W-1:0]}.
- advance = !out_valid || out_ready.
- hazard = out_valid && out_opcode==LOAD_OP && (instruction rs==out_rt || instruction rt==out_rt) && !(ZERO_REG && out_rt==0).
- in_ready = advance && (!hazard || flush).
- ID/EX update on clk, in priority order:
  - flush=1: out_valid<=0; the offered instruction is consumed and discarded.
  - else if advance and hazard: out_valid<=0 (bubble); instruction is held by fetch.
  - else if advance: out_valid<=in_valid; data fields load from decode.
  - else: all outputs hold.
- Latency: one cycle from accepted instruction to out_valid.
- Throughput: 1 instruction per cycle with no hazard. A load-use pair costs exactly one bubble cycle.
- Data fields may update on bubbles; consumers qualify them with out_valid.
- Simultaneous wb and decode of the same register: decode captures wb_data via bypass.
- Flush during hazard or back-pressure: flush wins, out_valid=0 next cycle.

Test Plan:
- Reset then idle -> out_valid=0, all out_* = 0; reading r1..r7 yields 0.
- wb_en=1, wb_addr=3, wb_data=16'h1234 in the same cycle as decoding rs=3 -> next cycle out_rs_data=16'h1234, out_valid=1.
- Instruction with imm=7'b1000001 at DATA_W=16 -> out_imm=16'hFFC1; imm=7'b0111111 -> 16'h003F.
- LOAD_OP with rt=2 in ID/EX, then an instruction with rs=2 -> in_ready=0 one cycle, one bubble (out_valid=0), then the instruction issues; a repeat with rt=0 and ZERO_REG=1 gives no stall.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; release -> the next instruction enters the following cycle.
- flush=1 with in_valid=1 while stalled -> in_ready=1, next cycle out_valid=0; rst asserted mid-stream -> next cycle everything zero, regardless of wb_en.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: register file with write-back bypass, immediate
// sign extension, load-use stall, flush, and a valid/ready ID/EX register.
module decode_stage_pipe #(
  parameter int          DATA_W   = 16,
  parameter int          IMM_W    = 7,
  parameter logic [2:0]  LOAD_OP  = 3'b100,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       instruction,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_rt,
  output logic [2:0]        out_rd
);

  logic [DATA_W-1:0] r_rf [8];

  logic [2:0]              w_opcode, w_rs, w_rt, w_rd;
  logic signed [IMM_W-1:0] w_imm_s;
  logic [DATA_W-1:0]       w_imm, w_rs_data, w_rt_data;
  logic                    w_advance, w_hazard, w_wb_ok;

  assign w_opcode = instruction[15:13];
  assign w_rs     = instruction[12:10];
  assign w_rt     = instruction[9:7];
  assign w_rd     = instruction[6:4];
  assign w_imm_s  = instruction[IMM_W-1:0];
  // Widening a signed value replicates its MSB; also legal when DATA_W == IMM_W.
  assign w_imm    = DATA_W'(w_imm_s);

  assign w_wb_ok  = wb_en && !(ZERO_REG && wb_addr == 3'd0);

  function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] idx);
    if (ZERO_REG && idx == 3'd0)   return '0;
    else if (w_wb_ok && wb_addr == idx) return wb_data;
    else                           return r_rf[idx];
  endfunction

  assign w_rs_data = rf_read(w_rs);
  assign w_rt_data = rf_read(w_rt);

  assign w_advance = !out_valid || out_ready;
  assign w_hazard  = out_valid && (out_opcode == LOAD_OP) &&
                     (w_rs == out_rt || w_rt == out_rt) &&
                     !(ZERO_REG && out_rt == 3'd0);
  assign in_ready  = w_advance && (!w_hazard || flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (w_wb_ok) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // Bubbles and flushes only clear out_valid; data fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_opcode  <= '0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_rt      <= '0;
      out_rd      <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (w_advance && w_hazard) begin
      out_valid   <= 1'b0;
    end else if (w_advance) begin
      out_valid   <= in_valid;
      out_opcode  <= w_opcode;
      out_rs_data <= w_rs_data;
      out_rt_data <= w_rt_data;
      out_imm     <= w_imm;
      out_rt      <= w_rt;
      out_rd      <= w_rd;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: reset, bypass, sign extension,
// load-use stall, back-pressure, flush and mid-stream reset.
module tb_decode_stage_pipe;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [15:0]       instruction;
  logic [2:0]        wb_addr, out_opcode, out_rt, out_rd;
  logic [DATA_W-1:0] wb_data, out_rs_data, out_rt_data, out_imm;

  int n_chk  = 0;
  int n_fail = 0;

  decode_stage_pipe #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
    .out_imm(out_imm), .out_rt(out_rt), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid",  out_valid,   0);
    chk("rst_opcode", out_opcode,  0);
    chk("rst_rs",     out_rs_data, 0);
    chk("rst_rt",     out_rt_data, 0);
    chk("rst_imm",    out_imm,     0);
    chk("rst_rtidx",  out_rt,      0);
    chk("rst_rd",     out_rd,      0);

    // Register file cleared by reset
    in_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      instruction = mk(3'd0, 3'(i), 3'(i), 7'd0);
      tick();
      chk("rf_zero_v",  out_valid,   1);
      chk("rf_zero_rs", out_rs_data, 0);
      chk("rf_zero_rt", out_rt_data, 0);
    end

    // Bypass of same-cycle write-back, negative immediate
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
    instruction = mk(3'd1, 3'd3, 3'd0, 7'b1000001);
    #1 chk("byp_inrdy", in_ready, 1);
    tick();
    wb_en = 1'b0;
    chk("byp_valid", out_valid,   1);
    chk("byp_rs",    out_rs_data, 16'h1234);
    chk("byp_op",    out_opcode,  1);
    chk("imm_neg",   out_imm,     16'hFFC1);
    chk("rd_neg",    out_rd,      4);

    // Stored value read back, positive immediate
    instruction = mk(3'd2, 3'd0, 3'd3, 7'b0111111);
    tick();
    chk("rf_rt",   out_rt_data, 16'h1234);
    chk("imm_pos", out_imm,     16'h003F);
    chk("rd_pos",  out_rd,      3);
    chk("rt_idx",  out_rt,      3);

    // Writes to r0 are dropped, including bypass
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    instruction = mk(3'd1, 3'd0, 3'd0, 7'd0);
    tick();
    wb_en = 1'b0;
    chk("r0_byp", out_rs_data, 0);
    tick();
    chk("r0_wr", out_rs_data, 0);

    // Load-use: r2 = 00A5, LOAD rt=2 then consumer rs=2
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00A5;
    tick();
    wb_en = 1'b0;
    in_valid = 1'b1; instruction = mk(3'b100, 3'd1, 3'd2, 7'd0);
    tick();
    chk("ld_valid", out_valid, 1);
    instruction = mk(3'd1, 3'd2, 3'd5, 7'd0);
    #1 chk("hz_inrdy0", in_ready, 0);
    tick();
    chk("hz_bubble", out_valid, 0);
    chk("hz_inrdy1", in_ready, 1);
    tick();
    chk("hz_issue_v",  out_valid,   1);
    chk("hz_issue_op", out_opcode,  1);
    chk("hz_issue_rs", out_rs_data, 16'h00A5);

    // LOAD with rt=0 never stalls
    instruction = mk(3'b100, 3'd1, 3'd0, 7'd0);
    tick();
    instruction = mk(3'd1, 3'd0, 3'd0, 7'd0);
    #1 chk("r0_nostall", in_ready, 1);
    tick();
    chk("r0_issue_v",  out_valid,  1);
    chk("r0_issue_op", out_opcode, 1);

    // Back-pressure for three cycles
    instruction = mk(3'd2, 3'd3, 3'd2, 7'd5);
    tick();
    out_ready = 1'b0;
    instruction = mk(3'd3, 3'd1, 3'd1, 7'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_inrdy", in_ready, 0);
      tick();
      chk("bp_valid", out_valid,   1);
      chk("bp_op",    out_opcode,  2);
      chk("bp_rs",    out_rs_data, 16'h1234);
      chk("bp_imm",   out_imm,     5);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_inrdy", in_ready, 1);
    tick();
    chk("bp_next_v",  out_valid,  1);
    chk("bp_next_op", out_opcode, 3);

    // Flush while stalled on load-use
    instruction = mk(3'b100, 3'd1, 3'd2, 7'd0);
    tick();
    instruction = mk(3'd1, 3'd2, 3'd0, 7'd0);
    #1 chk("fl_stall", in_ready, 0);
    flush = 1'b1;
    #1 chk("fl_inrdy", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    tick();
    chk("fl_discard", out_valid, 0);

    // Flush under back-pressure
    in_valid = 1'b1; instruction = mk(3'd5, 3'd1, 3'd1, 7'd0);
    tick();
    out_ready = 1'b0; flush = 1'b1;
    #1 chk("flbp_inrdy", in_ready, 0);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk("flbp_valid", out_valid, 0);

    // Reset mid-stream overrides write-back
    instruction = mk(3'd6, 3'd3, 3'd2, 7'h7F);
    tick();
    chk("pre_rst_v", out_valid, 1);
    rst = 1'b1; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h7777;
    tick();
    rst = 1'b0; wb_en = 1'b0;
    chk("mrst_valid", out_valid,   0);
    chk("mrst_op",    out_opcode,  0);
    chk("mrst_rs",    out_rs_data, 0);
    chk("mrst_imm",   out_imm,     0);
    chk("mrst_rd",    out_rd,      0);
    instruction = mk(3'd1, 3'd5, 3'd3, 7'd0);
    tick();
    chk("mrst_r5", out_rs_data, 0);
    chk("mrst_r3", out_rt_data, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
